gate_tt_sequencer: RTL

- Stimulus and checker stage wrapped around one 2-input lab gate (OR/AND/NAND/NOR/XOR).
- Upstream role: drives the gate's A/B inputs through all four input vectors.
- Downstream role: samples the gate's Y output after each vector and compares it with the expected truth table.
- Reports per-vector mismatches and an overall pass flag, for board-level lab checking of behavioural gate models.

---
 rtl/gate_pkg.sv | 20 ++
 rtl/gate_tt_expect.sv | 26 ++
 rtl/gate_tt_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate truth-table sequencer and its expected-value helper.
package gate_pkg;

    localparam logic [2:0] OP_OR   = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

    localparam int NUM_VECTORS = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } tt_state_t;

endpackage

// File: rtl/gate_tt_expect.sv
// Combinational reference for one 2-input gate: expected y and an illegal-op flag.
module gate_tt_expect
    import gate_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y,
    output logic       illegal
);

    // Truth table of the supported gate functions
    always_comb begin
        y       = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/gate_tt_sequencer.sv
// Drives a lab gate through all four input vectors and checks its output.
// Optional macro TTSEQ_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_tt_sequencer
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op_sel,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
);

    tt_state_t          state;
    tt_state_t          next_state;
    logic [2:0]         op_lat;
    logic [CNT_W-1:0]   cnt;

    logic [2:0]         op_lat_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               a_n;
    logic               b_n;
    logic               busy_n;
    logic               done_n;
    logic               pass_n;
    logic [3:0]         mask_n;
    logic [1:0]         idx_n;

    logic               exp_y;
    logic               op_bad;
    logic               mismatch;
    logic               last_vec;

    gate_tt_expect u_expect (
        .op      (op_lat),
        .a       (a_out),
        .b       (b_out),
        .y       (exp_y),
        .illegal (op_bad)
    );

    assign mismatch = (y_in != exp_y);
    assign last_vec = (vec_idx == 2'(NUM_VECTORS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_DRIVE;
                else       next_state = ST_IDLE;
            end
            ST_DRIVE: begin
                if (op_bad)                  next_state = ST_DONE;
                else if (SETTLE_CYCLES == 0) next_state = ST_SAMPLE;
                else                         next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt <= CNT_W'(1)) next_state = ST_SAMPLE;
                else                  next_state = ST_SETTLE;
            end
            ST_SAMPLE: begin
`ifdef TTSEQ_STOP_ON_FAIL_EN
                if (last_vec || mismatch) next_state = ST_DONE;
                else                      next_state = ST_DRIVE;
`else
                if (last_vec) next_state = ST_DONE;
                else          next_state = ST_DRIVE;
`endif
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        op_lat_n = op_lat;
        cnt_n    = cnt;
        a_n      = a_out;
        b_n      = b_out;
        pass_n   = pass;
        mask_n   = fail_mask;
        idx_n    = vec_idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    op_lat_n = op_sel;
                    mask_n   = 4'h0;
                    pass_n   = 1'b0;
                    idx_n    = 2'd0;
                end else begin
                    op_lat_n = op_lat;
                end
            end
            ST_DRIVE: begin
                if (op_bad) begin
                    mask_n = 4'hF;
                end else begin
                    a_n   = vec_idx[1];
                    b_n   = vec_idx[0];
                    cnt_n = CNT_W'(SETTLE_CYCLES);
                end
            end
            ST_SETTLE: cnt_n = cnt - CNT_W'(1);
            ST_SAMPLE: begin
                if (mismatch) mask_n[vec_idx] = 1'b1;
                else          mask_n = fail_mask;
                if (next_state == ST_DRIVE) idx_n = vec_idx + 2'd1;
                else                        idx_n = vec_idx;
            end
            ST_DONE:  cnt_n = cnt;
            default:  cnt_n = cnt;
        endcase
        busy_n = (next_state != ST_IDLE);
        // Gate inputs return low and the verdict is published as DONE is entered
        if (next_state == ST_DONE) begin
            done_n = 1'b1;
            a_n    = 1'b0;
            b_n    = 1'b0;
            pass_n = (mask_n == 4'h0);
        end else begin
            done_n = 1'b0;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_lat    <= 3'd0;
            cnt       <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'h0;
            vec_idx   <= 2'd0;
        end else begin
            op_lat    <= op_lat_n;
            cnt       <= cnt_n;
            a_out     <= a_n;
            b_out     <= b_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            fail_mask <= mask_n;
            vec_idx   <= idx_n;
        end
    end

endmodule
